// File: rtl/program_counter_stack_pkg.sv
// Shared action codes for the program counter and the instruction decoder.
// Used by program_counter_stack; optional return stack enabled with PC_RETURN_STACK_EN.
package program_counter_stack_pkg;

  localparam int PC_ACT_W = 3;

  typedef enum logic [PC_ACT_W-1:0] {
    PC_ACT_HOLD   = 3'b000,
    PC_ACT_INC    = 3'b001,
    PC_ACT_JUMP   = 3'b010,
    PC_ACT_BRANCH = 3'b011,
    PC_ACT_CALL   = 3'b100,
    PC_ACT_RET    = 3'b101
  } pc_action_e;

  // Codes 3'b11x are reserved and fold onto HOLD.
  function automatic pc_action_e decode_action(input logic [PC_ACT_W-1:0] code);
    if (code > 3'b101) begin
      return PC_ACT_HOLD;
    end
    return pc_action_e'(code);
  endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Control/status bundle between the register controller and the program counter.
// The status flags are only live when the design is built with PC_RETURN_STACK_EN.
interface program_counter_stack_if
  import program_counter_stack_pkg::*;
#(
  parameter int PC_WIDTH = 8
);

  logic                i_pc_en;
  logic [PC_ACT_W-1:0] i_action;
  logic [PC_WIDTH-1:0] i_data;
  logic [PC_WIDTH-1:0] o_pc;
  logic                o_stack_empty;
  logic                o_stack_full;
  logic                o_stack_err;

  modport master (
    output i_pc_en, i_action, i_data,
    input  o_pc, o_stack_empty, o_stack_full, o_stack_err
  );

  modport slave (
    input  i_pc_en, i_action, i_data,
    output o_pc, o_stack_empty, o_stack_full, o_stack_err
  );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with full/empty and a sticky overflow/underflow flag.
// Instantiated by program_counter_stack only under PC_RETURN_STACK_EN.
module pc_return_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full,
  output logic                err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]     sp_reg;
  logic                err_reg;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (sp_reg == SP_W'(STACK_DEPTH));
  assign empty   = (sp_reg == '0);
  assign err     = err_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Depth is a power of two, so the low bits of sp index the next free slot
  // and wrap to the last slot when sp == STACK_DEPTH.
  assign wr_idx = sp_reg[IDX_W-1:0];
  assign rd_idx = sp_reg[IDX_W-1:0] - 1'b1;
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        sp_reg <= sp_reg + 1'b1;
      end else if (pop_ok) begin
        sp_reg <= sp_reg - 1'b1;
      end
      if ((push && full) || (pop && empty)) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment, jump, signed branch and optional call/return stack.
// Define PC_RETURN_STACK_EN to build the return stack; otherwise CALL=JUMP and RET=HOLD.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int                PC_WIDTH     = 8,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_counter_stack_if.slave bus
);

  if ((PC_WIDTH < 4) || (STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_param_check
    $error("program_counter_stack: PC_WIDTH must be >= 4 and STACK_DEPTH a power of 2 >= 2");
  end

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_plus_one;

  assign pc_plus_one = pc_reg + PC_WIDTH'(1);

`ifdef PC_RETURN_STACK_EN
  logic                push_req;
  logic                pop_req;
  logic [PC_WIDTH-1:0] stack_top;
  logic                stack_empty;
  logic                stack_full;
  logic                stack_err;

  pc_return_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (pc_plus_one),
    .top       (stack_top),
    .empty     (stack_empty),
    .full      (stack_full),
    .err       (stack_err)
  );

  assign bus.o_stack_empty = stack_empty;
  assign bus.o_stack_full  = stack_full;
  assign bus.o_stack_err   = stack_err;
`else
  assign bus.o_stack_empty = 1'b1;
  assign bus.o_stack_full  = 1'b0;
  assign bus.o_stack_err   = 1'b0;
`endif

  always_comb begin
    pc_next = pc_reg;
`ifdef PC_RETURN_STACK_EN
    push_req = 1'b0;
    pop_req  = 1'b0;
`endif
    if (bus.i_pc_en) begin
      case (decode_action(bus.i_action))
        PC_ACT_INC:    pc_next = pc_plus_one;
        PC_ACT_JUMP:   pc_next = bus.i_data;
        // Modulo-2^W addition of the raw offset equals adding its sign extension.
        PC_ACT_BRANCH: pc_next = pc_reg + bus.i_data;
`ifdef PC_RETURN_STACK_EN
        PC_ACT_CALL: begin
          push_req = 1'b1;
          if (!stack_full) begin
            pc_next = bus.i_data;
          end
        end
        PC_ACT_RET: begin
          pop_req = 1'b1;
          if (!stack_empty) begin
            pc_next = stack_top;
          end
        end
`else
        PC_ACT_CALL:   pc_next = bus.i_data;
        PC_ACT_RET:    pc_next = pc_reg;
`endif
        default:       pc_next = pc_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign bus.o_pc = pc_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed sequences plus random traffic
// against a queue-based model; follows whether PC_RETURN_STACK_EN is defined.
module tb_program_counter_stack;

  localparam int         W     = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'h00;
`ifdef PC_RETURN_STACK_EN
  localparam bit HAS_STACK = 1'b1;
`else
  localparam bit HAS_STACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_counter_stack_if #(.PC_WIDTH(W)) bus ();

  program_counter_stack #(
    .PC_WIDTH     (W),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: predicted architectural state after the next posedge.
  logic [7:0] m_pc = RV;
  logic [7:0] m_stk [$];
  bit         m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rn, input logic en, input logic [2:0] act, input logic [7:0] d);
    if (!rn) begin
      m_pc  = RV;
      m_stk.delete();
      m_err = 1'b0;
    end else if (en) begin
      case (act)
        3'd1: m_pc = m_pc + 8'd1;
        3'd2: m_pc = d;
        3'd3: m_pc = 8'(int'(m_pc) + int'($signed(d)));
        3'd4: begin
          if (!HAS_STACK) m_pc = d;
          else if (m_stk.size() == DEPTH) m_err = 1'b1;
          else begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = d;
          end
        end
        3'd5: begin
          if (HAS_STACK) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic rn, input logic en, input logic [2:0] act, input logic [7:0] d);
    @(negedge clk);
    rst_n        = rn;
    bus.i_pc_en  = en;
    bus.i_action = act;
    bus.i_data   = d;
    model_update(rn, en, act, d);
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
    $display("step rst_n=%0b en=%0b act=%0d data=0x%02h -> pc=0x%02h empty=%0b full=%0b err=%0b",
             rn, en, act, d, bus.o_pc, bus.o_stack_empty, bus.o_stack_full, bus.o_stack_err);
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("pc",    bus.o_pc,          m_pc);
      check("empty", bus.o_stack_empty, (m_stk.size() == 0));
      check("full",  bus.o_stack_full,  (m_stk.size() == DEPTH));
      check("err",   bus.o_stack_err,   m_err);
    end
  end

  initial begin
    bus.i_pc_en  = 1'b0;
    bus.i_action = 3'd0;
    bus.i_data   = 8'h00;

    // 1: reset then counting
    step(1'b0, 1'b0, 3'd0, 8'h00);
    check("rst_pc", bus.o_pc, 8'h00);
    check("rst_empty", bus.o_stack_empty, 1'b1);
    check("rst_full", bus.o_stack_full, 1'b0);
    check("rst_err", bus.o_stack_err, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 3'd1, 8'h00);
      check("inc_pc", bus.o_pc, 8'(i));
    end
    step(1'b1, 1'b0, 3'd1, 8'h00);
    check("hold_en0", bus.o_pc, 8'h05);
    check("model_pin_hold", m_pc, 8'h05);

    // 2: jump and wrap
    step(1'b1, 1'b1, 3'd2, 8'hFE);
    check("jump_fe", bus.o_pc, 8'hFE);
    step(1'b1, 1'b1, 3'd1, 8'h00);
    check("inc_ff", bus.o_pc, 8'hFF);
    step(1'b1, 1'b1, 3'd1, 8'h00);
    check("inc_wrap", bus.o_pc, 8'h00);

    // 3: signed branch
    step(1'b1, 1'b1, 3'd2, 8'h10);
    step(1'b1, 1'b1, 3'd3, 8'hFC);
    check("branch_neg", bus.o_pc, 8'h0C);
    check("model_pin_branch", m_pc, 8'h0C);
    step(1'b1, 1'b1, 3'd3, 8'h04);
    check("branch_pos", bus.o_pc, 8'h10);

    // 4: nested call/return
    step(1'b1, 1'b1, 3'd2, 8'h20);
    step(1'b1, 1'b1, 3'd4, 8'h40);
    step(1'b1, 1'b1, 3'd4, 8'h50);
    check("call2_pc", bus.o_pc, 8'h50);
    check("call2_empty", bus.o_stack_empty, !HAS_STACK);
    step(1'b1, 1'b1, 3'd5, 8'h00);
    check("ret1_pc", bus.o_pc, HAS_STACK ? 8'h41 : 8'h50);
    step(1'b1, 1'b1, 3'd5, 8'h00);
    check("ret2_pc", bus.o_pc, HAS_STACK ? 8'h21 : 8'h50);
    check("ret2_empty", bus.o_stack_empty, 1'b1);

    // 5: overflow, reset mid-sequence, underflow
    step(1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 3'd4, 8'(i * 16));
    check("four_calls_full", bus.o_stack_full, HAS_STACK);
    step(1'b1, 1'b1, 3'd4, 8'h80);
    check("overflow_pc", bus.o_pc, HAS_STACK ? 8'h40 : 8'h80);
    check("overflow_err", bus.o_stack_err, HAS_STACK);
    step(1'b0, 1'b1, 3'd4, 8'h99);
    check("midrst_pc", bus.o_pc, 8'h00);
    check("midrst_empty", bus.o_stack_empty, 1'b1);
    check("midrst_err", bus.o_stack_err, 1'b0);
    step(1'b1, 1'b1, 3'd5, 8'h00);
    check("underflow_pc", bus.o_pc, 8'h00);
    check("underflow_err", bus.o_stack_err, HAS_STACK);

    // 6: call/return collapse to jump/hold without the stack; reserved codes hold
    step(1'b1, 1'b1, 3'd4, 8'h33);
    check("call33_pc", bus.o_pc, 8'h33);
    step(1'b1, 1'b1, 3'd5, 8'h00);
    check("ret_after_call", bus.o_pc, HAS_STACK ? 8'h01 : 8'h33);
    step(1'b1, 1'b1, 3'd6, 8'hAA);
    step(1'b1, 1'b1, 3'd7, 8'hBB);
    check("reserved_hold", bus.o_pc, HAS_STACK ? 8'h01 : 8'h33);

    // Random traffic, biased towards CALL/RET so the stack fills and drains.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [2:0] act;
      sel = int'($urandom_range(0, 11));
      act = (sel >= 8) ? ((sel >= 10) ? 3'd5 : 3'd4) : 3'(sel);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), act, 8'($urandom));
    end

    cmp_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
